// File: rtl/screen_draw_ctrl.sv
// Full-screen raster scanner for a 160x120 VGA plotter fed from an image ROM.
// Latency: addr 0 in the first cycle after accept, plots lag addr by one cycle; done 19202 cycles after accept.
// No backpressure: requests are sampled only in IDLE and ignored while busy.
// Optional feature macro CLEAR_BEFORE_DRAW_EN: a start runs a black CLEAR pass then a DRAW pass back to back.
module screen_draw_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        clearReq,
  input  logic [6:0]  imageSel,
  output logic [14:0] addr,
  output logic [6:0]  memorySel,
  output logic        black,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [14:0] ADDR_LAST = 15'd19199;
  localparam logic [7:0]  COL_LAST  = 8'd159;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        plot_q, plot_d;
  logic        black_q, black_d;
  logic [6:0]  msel_q, msel_d;
  // Set when a CLEAR pass must chain straight into a DRAW pass.
  logic        draw_after_q, draw_after_d;

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      plot_q       <= 1'b0;
      black_q      <= 1'b0;
      msel_q       <= '0;
      draw_after_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      plot_q       <= plot_d;
      black_q      <= black_d;
      msel_q       <= msel_d;
      draw_after_q <= draw_after_d;
    end
  end

  // Next-state logic: request arbitration in IDLE, raster scan in CLEAR/DRAW.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    plot_d       = 1'b0;
    black_d      = 1'b0;
    msel_d       = msel_q;
    draw_after_d = draw_after_q;

    case (state_q)
      S_IDLE: begin
        addr_d       = '0;
        col_d        = '0;
        row_d        = '0;
        draw_after_d = 1'b0;
        // Clear wins over start; the losing start is simply dropped.
        if (clearReq) begin
          state_d = S_CLEAR;
        end else if (start) begin
          msel_d = imageSel;
`ifdef CLEAR_BEFORE_DRAW_EN
          state_d      = S_CLEAR;
          draw_after_d = 1'b1;
`else
          state_d = S_DRAW;
`endif
        end
      end

      S_CLEAR, S_DRAW: begin
        // The ROM answers one cycle later, so the plot registers carry
        // this cycle's scan position into the next cycle.
        x_d     = col_q;
        y_d     = row_q;
        plot_d  = 1'b1;
        black_d = (state_q == S_CLEAR);
        if (addr_q == ADDR_LAST) begin
          addr_d = '0;
          col_d  = '0;
          row_d  = '0;
          if (state_q == S_CLEAR && draw_after_q) begin
            state_d      = S_DRAW;
            draw_after_d = 1'b0;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          addr_d = addr_q + 15'd1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end

      // One cycle to let the final pipelined plot reach the output.
      S_FLUSH: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign addr      = addr_q;
  assign memorySel = msel_q;
  assign black     = black_q;
  assign x         = x_q;
  assign y         = y_q;
  assign plot      = plot_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl: draw pass, clear pass with a
// mid-pass start, and an asynchronous reset in the middle of a draw.
module tb_screen_draw_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        clearReq;
  logic [6:0]  imageSel;
  logic [14:0] addr;
  logic [6:0]  memorySel;
  logic        black;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        plot;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

`ifdef CLEAR_BEFORE_DRAW_EN
  localparam logic [6:0] SEL1 = 7'd41;
  localparam int START_PLOTS = 38400;
  localparam int START_DONE  = 38402;
  localparam int START_BLACK = 19200;
`else
  localparam logic [6:0] SEL1 = 7'd11;
  localparam int START_PLOTS = 19200;
  localparam int START_DONE  = 19202;
  localparam int START_BLACK = 0;
`endif

  screen_draw_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .clearReq  (clearReq),
    .imageSel  (imageSel),
    .addr      (addr),
    .memorySel (memorySel),
    .black     (black),
    .x         (x),
    .y         (y),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 (just after the accepting edge E0). Walks the pass
  // cycle by cycle, comparing every plot against the row-major raster.
  task automatic watch(input int exp_plots, input int exp_done, input int n_black,
                       input logic [6:0] exp_msel, input int pulse_cycle);
    int plots = 0, bad_seq = 0, bad_addr = 0, bad_busy = 0, bad_msel = 0;
    int first_plot = -1, last_plot = -1, gaps = 0, done_cyc = -1, done_cnt = 0;
    int lx = -1, ly = -1, x159 = -1, y159 = -1, x160 = -1, y160 = -1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      if (plot === 1'b1) begin
        int seg, ex, ey;
        logic eb;
        seg = plots % 19200;
        ex  = seg % 160;
        ey  = seg / 160;
        eb  = (plots < n_black);
        if (x !== ex[7:0] || y !== ey[6:0] || black !== eb) bad_seq++;
        if (seg == 159) begin x159 = int'(x); y159 = int'(y); end
        if (seg == 160) begin x160 = int'(x); y160 = int'(y); end
        if (first_plot < 0) first_plot = c;
        if (last_plot >= 0 && c != last_plot + 1) gaps++;
        last_plot = c;
        lx = int'(x);
        ly = int'(y);
        plots++;
      end else if (plot !== 1'b0) begin
        bad_seq++;
      end
      if (c <= exp_plots && addr !== 15'((c - 1) % 19200)) bad_addr++;
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (busy !== (c <= exp_done)) bad_busy++;
      if (memorySel !== exp_msel) bad_msel++;
      start = (c == pulse_cycle);
      tick();
    end
    start = 1'b0;
    chk("plot_count", plots, exp_plots);
    chk("first_plot_cycle", first_plot, 2);
    chk("last_plot_cycle", last_plot, exp_done - 1);
    chk("plot_gaps", gaps, 0);
    chk("raster_seq_errs", bad_seq, 0);
    chk("x_at_col159_row0", x159, 159);
    chk("y_at_col159_row0", y159, 0);
    chk("x_after_wrap", x160, 0);
    chk("y_after_wrap", y160, 1);
    chk("last_x", lx, 159);
    chk("last_y", ly, 119);
    chk("addr_errs", bad_addr, 0);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_cnt, 1);
    chk("busy_errs", bad_busy, 0);
    chk("memsel_errs", bad_msel, 0);
  endtask

  initial begin
    int done_seen, busy_seen;
    resetn   = 1'b0;
    start    = 1'b1;
    clearReq = 1'b0;
    imageSel = SEL1;
    repeat (3) tick();

    // Reset state while a start is already pending.
    chk("rst_addr", addr, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_plot", plot, 0);
    chk("rst_black", black, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_memsel", memorySel, 0);

    // Release; the following edge is E0 and accepts the held start.
    resetn = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_memsel", memorySel, SEL1);
    chk("accept_addr", addr, 0);
    chk("accept_plot", plot, 0);
    watch(START_PLOTS, START_DONE, START_BLACK, SEL1, 0);
    chk("idle_busy", busy, 0);
    chk("idle_plot", plot, 0);

    // Start and clear together: clear wins, memorySel keeps its value,
    // and a start pulsed at cycle 500 is ignored.
    start    = 1'b1;
    clearReq = 1'b1;
    imageSel = 7'd99;
    tick();
    start    = 1'b0;
    clearReq = 1'b0;
    watch(19200, 19202, 19200, SEL1, 500);
    tick();
    chk("post_clear_busy", busy, 0);
    chk("post_clear_memsel", memorySel, SEL1);

    // Reset in the middle of a pass.
    start    = 1'b1;
    imageSel = 7'd23;
    tick();
    start = 1'b0;
    repeat (9999) tick();
    chk("mid_plot", plot, 1);
    chk("mid_busy", busy, 1);
    chk("mid_memsel", memorySel, 23);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_plot", plot, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_addr", addr, 0);
    chk("arst_memsel", memorySel, 0);
    repeat (3) tick();
    resetn = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 1'b0) done_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    chk("after_rst_done", done_seen, 0);
    chk("after_rst_busy", busy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_draw_ctrl.md
SCREEN_DRAW_CTRL -- requirements
Module: screen_draw_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  draw request, sampled in IDLE only.
REQ-004 clearReq  input  1  clear-screen (black fill) request, sampled in IDLE only.
REQ-005 imageSel  input  7  image index to draw, latched when start is accepted.
REQ-006 addr  output  15  ROM read address, y*160+x, 0..19199.
REQ-007 memorySel  output  7  image select for the colour mux; latched imageSel.
REQ-008 black  output  1  forces colour mux to 3'b000 during a clear pass.
REQ-009 x  output  8  VGA plot x, 0..159.
REQ-010 y  output  7  VGA plot y, 0..119.
REQ-011 plot  output  1  VGA write enable for (x,y).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of pass sequence.

Function
REQ-014 States: IDLE, CLEAR, DRAW, FLUSH, DONE.
REQ-015 IDLE: clearReq=1 -> CLEAR; else start=1 -> DRAW; clearReq wins when both high, start dropped.
REQ-016 start/clearReq while busy are ignored, not queued.
REQ-017 CLEAR and DRAW each issue one address per cycle, addr 0..19199 in row-major order; internal scan column 0..159, row 0..119.
REQ-018 Column wraps 159->0 and row increments in the same cycle; after column 159 row 119, address counter resets to 0.
REQ-019 ROM read latency is one cycle: x, y, plot are registered copies of the scan position/valid issued the previous cycle.
REQ-020 black is 1 for all plots of a CLEAR pass and 0 for all plots of a DRAW pass, aligned with plot.
REQ-021 After the last address (19199) the FSM enters FLUSH for one cycle to emit the final plot, then DONE for one cycle (done=1), then IDLE.
REQ-022 Latency, start sampled at edge E0: addr 0 driven in cycle 1, first plot cycle 2, last plot cycle 19201, done cycle 19202; exactly 19200 plot cycles per pass, no gaps.
REQ-023 memorySel holds its latched value from accept until the next accepted start; a clear pass does not change it.
REQ-024 Address arithmetic is unsigned; no out-of-range coordinate (x>159, y>119) is ever driven with plot=1.

Reset
REQ-025 resetn=0 forces immediately, regardless of clk: state=IDLE, addr=0, x=0, y=0, plot=0, black=0, busy=0, done=0, memorySel=0.
REQ-026 Reset mid-pass aborts the pass; no done pulse is produced; after release the block waits in IDLE for a new request.

Configuration
REQ-027 Macro CLEAR_BEFORE_DRAW_EN: when defined, an accepted start first runs a full CLEAR pass then, on the next cycle with no gap, a DRAW pass (IDLE->CLEAR->DRAW->FLUSH->DONE), done at cycle 38402 after E0; clearReq behaviour unchanged.
REQ-028 When CLEAR_BEFORE_DRAW_EN is undefined, start goes straight to DRAW with timing per REQ-022.

Verification
REQ-029 resetn low, start=1 imageSel=7'd11 -> after release, sample start at E0: memorySel=11, busy=1 cycle 1, plot cycle 2 at (0,0), done=1 only at cycle 19202.
REQ-030 Full DRAW pass -> count exactly 19200 plots, each (x,y) unique, plot at (159,0) followed next cycle by (0,1), last plot (159,119), black=0 throughout.
REQ-031 start=1 and clearReq=1 same cycle in IDLE -> CLEAR pass, black=1 on all 19200 plots, memorySel unchanged.
REQ-032 start pulsed at cycle 500 of a pass -> ignored; single done pulse; block returns to IDLE with busy=0.
REQ-033 resetn asserted at cycle 10000 of DRAW -> plot, busy, done, x, y drop to 0 asynchronously; no done ever pulses for that pass.
REQ-034 With CLEAR_BEFORE_DRAW_EN defined, start imageSel=7'd41 -> 19200 plots black=1 then 19200 plots black=0, done at cycle 38402.
